ext_share_arbiter: RTL
======================

# ext_share_arbiter

Shares one immediate-extension unit between two requesters in the mips32 datapath: decode (requester 0) and branch/address unit (requester 1). Each request carries a 16-bit immediate and an extension mode. A round-robin arbiter grants one request per cycle, computes the 32-bit result, and holds it in a single-entry output register with a valid/ready handshake toward the consumer.

## Interface
- IMM_W, 16, immediate width (fixed; only 16 supported)
- OUT_W, 32, extended result width (fixed; only 32 supported)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req0_valid  in  1  requester 0 has a request
- req0_imm  in  16  requester 0 immediate
- req0_mode  in  2  requester 0 mode: 00 zero, 01 sign, 10 lui, 11 reserved
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid / req1_imm / req1_mode / req1_ready: same as requester 0, for requester 1
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  consumer accepts result
- out_data  out  32  extended result
- out_id  out  1  requester that owns out_data
- out_err  out  1  result came from an illegal mode

## Operation
- **State:** output register `{out_valid, out_data, out_id, out_err}` plus `last_grant` (1 bit).
- **Slot free** when `!out_valid || out_ready`.
- **Arbitration (round-robin):**
  - Only one requester valid: it is granted.
  - Both valid: grant the requester != `last_grant`.
  - `last_grant` updates only on an accepted request.
- **Ready:** `reqN_ready = grant_N && slot_free`.
  - Combinational from valids, `last_grant`, `out_valid`, `out_ready`.
  - Never asserted for a non-valid requester.
  - At most one ready per cycle.
- **Accept:** `reqN_valid && reqN_ready`. On the next edge:
  - `out_valid` = 1, `out_id` = N.
  - `out_data` = extend(imm, mode); `out_err` = mode illegal.
- **Extension:**
  - 00: `{16'h0000, imm}`.
  - 01: `{{16{imm[15]}}, imm}`.
  - 10: `{imm, 16'h0000}`.
  - 11: `{16'h0000, imm}` with `out_err` = 1.
- **Output:**
  - Consumer handshake with no new accept: `out_valid` clears next edge; `out_data`, `out_id`, `out_err` hold their last values.
  - Handshake and accept in the same cycle: the register reloads with the new result; `out_valid` stays 1.
- **Stable while stalled:** `out_data`, `out_id`, `out_err` do not change while `out_valid && !out_ready`.
- **Requester stall:** a requester that is not granted, or is stalled, must hold valid/imm/mode until ready.

## Timing
- **Reset values:** `out_valid` 0, `out_data` 32'h0, `out_id` 0, `out_err` 0, `last_grant` 1 (requester 0 wins the first contention).
- **Latency:** 1 cycle from accept edge to `out_valid`.
- **Throughput:** 1 result/cycle while `out_ready` is held high.
- **Full register with `out_ready` = 0:** both readies are 0; no request is lost.
- **Reset mid-operation:** the held result is discarded; `out_valid` drops immediately (asynchronous). The first edge after reset deasserts behaves as from reset.
- **Simultaneous events:** both requesters valid in the same cycle as a consumer handshake is legal. Exactly one is accepted, per round-robin.
- **Fairness:** under continuous contention, grants alternate 0,1,0,1…

## Configuration
- **Macro:** `EXT_SHARE_LUI_EN`.
- **Defined:** mode 10 performs lui extension (imm << 16), `out_err` = 0.
- **Undefined:**
  - Mode 10 is illegal: result is `{16'h0000, imm}` with `out_err` = 1.
  - The lui shift path is not synthesized.

## Test plan
- **Reset and single request:** reset, then req0 {imm=16'h8001, mode=01} with `out_ready`=1 → `req0_ready`=1. Next cycle `out_valid`=1, `out_data`=32'hFFFF8001, `out_id`=0, `out_err`=0.
- **Contention:** both valid continuously (req0 imm=16'h0001 mode 00, req1 imm=16'h0002 mode 00), `out_ready`=1 → `out_id` sequence 0,1,0,1. One result per cycle after the first.
- **Backpressure:** `out_ready`=0 with a result held → both readies 0 for 5 cycles, `out_data` unchanged. Raise `out_ready` → pending req1 accepted the same cycle; new result on the next edge.
- **Illegal mode:** req1 {imm=16'hABCD, mode=11} → `out_data`=32'h0000ABCD, `out_err`=1, `out_id`=1.
- **Lui mode:** req0 {imm=16'h1234, mode=10}:
  - with `EXT_SHARE_LUI_EN` → `out_data`=32'h12340000, `out_err`=0;
  - without → `out_data`=32'h00001234, `out_err`=1.
- **Async reset mid-hold:** assert reset between edges while `out_valid`=1 → `out_valid`=0 before the next edge. After release, a contention grants requester 0 first.

Source files
------------

// File: rtl/ext_share_arbiter_if.sv
// ext_share_arbiter_if: request and result handshake bundle for the shared
// immediate-extension unit.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high.
// - A requester raises reqN_valid and holds reqN_imm/reqN_mode stable until
//   it sees reqN_ready.
// - reqN_ready never rises without reqN_valid.
// - The result side presents out_valid with out_data/out_id/out_err held
//   stable until out_ready is seen.
interface ext_share_arbiter_if #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
);
    logic             req0_valid;
    logic [IMM_W-1:0] req0_imm;
    logic [1:0]       req0_mode;
    logic             req0_ready;

    logic             req1_valid;
    logic [IMM_W-1:0] req1_imm;
    logic [1:0]       req1_mode;
    logic             req1_ready;

    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_id;
    logic             out_err;

    // Requesters and the consumer.
    modport master (
        output req0_valid, req0_imm, req0_mode,
        input  req0_ready,
        output req1_valid, req1_imm, req1_mode,
        input  req1_ready,
        input  out_valid, out_data, out_id, out_err,
        output out_ready
    );

    // The arbiter.
    modport slave (
        input  req0_valid, req0_imm, req0_mode,
        output req0_ready,
        input  req1_valid, req1_imm, req1_mode,
        output req1_ready,
        output out_valid, out_data, out_id, out_err,
        input  out_ready
    );
endinterface

// File: rtl/ext_share_arbiter.sv
// ext_share_arbiter: round-robin sharing of one 16->32 immediate-extension
// unit between decode (requester 0) and the branch/address unit
// (requester 1). The result sits in a single-entry output register.
//
// Optional feature: define EXT_SHARE_LUI_EN to enable mode 2'b10
// (lui, imm << 16). Without it mode 2'b10 is flagged illegal like 2'b11.
module ext_share_arbiter #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
) (
    input  logic clk,
    input  logic reset,
    ext_share_arbiter_if.slave bus
);
    localparam int PAD_W = OUT_W - IMM_W;

    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic             out_id_q;
    logic             out_err_q;
    // Requester granted at the last accept; reset to 1 so requester 0 wins
    // the first contention.
    logic             last_grant_q;

    logic             slot_free;
    logic             grant0;
    logic             grant1;
    logic             ready0;
    logic             ready1;
    logic             accept;
    logic [IMM_W-1:0] sel_imm;
    logic [1:0]       sel_mode;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;

    // Round-robin grant, gated by the output slot being free this cycle.
    always_comb begin
        slot_free = !out_valid_q || bus.out_ready;
        grant0    = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1    = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        ready0    = grant0 && slot_free;
        ready1    = grant1 && slot_free;
        accept    = ready0 || ready1;
        sel_imm   = ready1 ? bus.req1_imm  : bus.req0_imm;
        sel_mode  = ready1 ? bus.req1_mode : bus.req0_mode;
    end

    // Immediate extension of the granted request.
    always_comb begin
        ext_data = {{PAD_W{1'b0}}, sel_imm};
        ext_err  = 1'b0;
        case (sel_mode)
            2'b01: ext_data = {{PAD_W{sel_imm[IMM_W-1]}}, sel_imm};
`ifdef EXT_SHARE_LUI_EN
            2'b10: ext_data = {sel_imm, {PAD_W{1'b0}}};
`else
            2'b10: ext_err  = 1'b1;
`endif
            2'b11: ext_err  = 1'b1;
            default: ;
        endcase
    end

    // Output register and round-robin pointer; a new accept takes priority
    // over draining, so a same-cycle handshake and accept reloads the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= 1'b0;
            out_err_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= ext_data;
            out_id_q     <= ready1;
            out_err_q    <= ext_err;
            last_grant_q <= ready1;
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_err    = out_err_q;
endmodule
